// File: rtl/cpu_pkg.sv
// Shared definitions for the memory access unit: FSM encoding, local window tag
// and the address-decode helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCAL    = 2'd1,
    ST_BUS_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } mau_state_e;

  localparam logic [3:0] LOCAL_TAG_DEFAULT = 4'h3;

  function automatic logic is_local_addr(input logic [3:0] top_nibble,
                                         input logic [3:0] tag);
    return (top_nibble == tag);
  endfunction

endpackage

// File: rtl/thread_regfile.sv
// Per-thread local register window: one write port, one combinational read
// port, every entry cleared by synchronous reset.
module thread_regfile #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array with reset-to-zero and a single write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end else begin
      mem_q[waddr_i] <= mem_q[waddr_i];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding memory access unit: routes each request either to the
// per-thread local register window or to the external W_* bus with a timeout.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter int         ADDR_W    = 32,
  parameter int         THREAD_W  = 2,
  parameter int         REG_SEL_W = 3,
  parameter logic [3:0] LOCAL_TAG = LOCAL_TAG_DEFAULT,
  parameter int         TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [THREAD_W-1:0] req_thread,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_ack,
  output logic                resp_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   W_ADDR,
  output logic [DATA_W-1:0]   W_DATA_O,
  input  logic [DATA_W-1:0]   W_DATA_I,
  output logic                W_WRITE,
  output logic                W_REQ,
  input  logic                W_ACK
);

  localparam int          IDX_W   = THREAD_W + REG_SEL_W;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  mau_state_e            state_q, state_d;
  logic [REG_SEL_W-1:0]  sel_q, sel_d;
  logic [THREAD_W-1:0]   thread_q, thread_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;
  logic                  resp_ack_q, resp_ack_d;
  logic                  resp_err_q, resp_err_d;
  logic                  busy_q, busy_d;
  logic                  w_req_q, w_req_d;
  logic                  w_write_q, w_write_d;
  logic [ADDR_W-1:0]     w_addr_q, w_addr_d;
  logic [DATA_W-1:0]     w_data_q, w_data_d;
  logic                  rf_we_s;
  logic [DATA_W-1:0]     rf_rdata_s;

  thread_regfile #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (rf_we_s),
    .waddr_i ({thread_q, sel_q}),
    .wdata_i (wdata_q),
    .raddr_i ({thread_q, sel_q}),
    .rdata_o (rf_rdata_s)
  );

  // Next-state and next-output computation for the access FSM
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    thread_d    = thread_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_ack_d  = 1'b0;
    resp_err_d  = 1'b0;
    w_req_d     = w_req_q;
    w_write_d   = w_write_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    rf_we_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sel_d    = req_addr[REG_SEL_W-1:0];
          thread_d = req_thread;
          wdata_d  = req_wdata;
          write_d  = req_write;
          cnt_d    = 16'd0;
          if (is_local_addr(req_addr[ADDR_W-1 -: 4], LOCAL_TAG)) begin
            state_d = ST_LOCAL;
          end else begin
            state_d   = ST_BUS_WAIT;
            w_req_d   = 1'b1;
            w_addr_d  = req_addr;
            w_data_d  = req_wdata;
            w_write_d = req_write;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCAL: begin
        rf_we_s    = write_q;
        resp_ack_d = 1'b1;
        state_d    = ST_DONE;
        if (!write_q) begin
          resp_data_d = rf_rdata_s;
        end else begin
          resp_data_d = resp_data_q;
        end
      end
      ST_BUS_WAIT: begin
        // An acknowledge on the timeout edge still completes without error
        if (W_ACK) begin
          w_req_d    = 1'b0;
          w_write_d  = 1'b0;
          resp_ack_d = 1'b1;
          state_d    = ST_DONE;
          if (!write_q) begin
            resp_data_d = W_DATA_I;
          end else begin
            resp_data_d = resp_data_q;
          end
        end else if (cnt_q == TO_LAST) begin
          w_req_d     = 1'b0;
          w_write_d   = 1'b0;
          resp_ack_d  = 1'b1;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        w_req_d   = 1'b0;
        w_write_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      thread_q    <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      cnt_q       <= 16'd0;
      resp_data_q <= '0;
      resp_ack_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      w_req_q     <= 1'b0;
      w_write_q   <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      thread_q    <= thread_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_ack_q  <= resp_ack_d;
      resp_err_q  <= resp_err_d;
      busy_q      <= busy_d;
      w_req_q     <= w_req_d;
      w_write_q   <= w_write_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_ack  = resp_ack_q;
  assign resp_err  = resp_err_q;
  assign busy      = busy_q;
  assign W_REQ     = w_req_q;
  assign W_WRITE   = w_write_q;
  assign W_ADDR    = w_addr_q;
  assign W_DATA_O  = w_data_q;

endmodule
